// File: rtl/trigger_ctrl_pkg.sv
// Shared definitions for the trigger/readout sequencer: FSM encodings,
// header error bit positions and counter widths.
package trigger_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_PKT = 3'd1,
    ST_WAIT_DAQ = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_REARM    = 3'd4
  } state_t;

  localparam int ERR_CRC = 0;
  localparam int ERR_ID  = 1;
  localparam int ERR_SEQ = 2;
  localparam int ERR_TMO = 3;
  localparam int ERR_W   = 4;

  localparam int TRIG_CNT_W = 32;
  localparam int ERR_CNT_W  = 16;
  localparam int SERIAL_W   = 32;

  function automatic logic [ERR_W-1:0] make_hdr_err(input logic tmo, input logic seq,
                                                    input logic id, input logic crc);
    logic [ERR_W-1:0] e;
    e          = '0;
    e[ERR_TMO] = tmo;
    e[ERR_SEQ] = seq;
    e[ERR_ID]  = id;
    e[ERR_CRC] = crc;
    return e;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear has priority.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/trigger_daq_sequencer.sv
// Runs one trigger -> header -> readout -> busy_clear cycle around the trigger
// receiver and keeps slow-control error counters.
module trigger_daq_sequencer
  import trigger_ctrl_pkg::*;
#(
  parameter logic [7:0] SUBSYS_ID   = 8'h00,
  parameter int         TIMEOUT_CYC = 200000,
  parameter int         CLEAR_LEN   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic                  end_flag,
  input  logic                  crc_status,
  input  logic [7:0]            sub_system_id,
  input  logic [7:0]            trigger_type,
  input  logic [SERIAL_W-1:0]   trigger_serial,
  output logic                  busy_clear,
  output logic                  daq_trig,
  output logic                  hdr_valid,
  input  logic                  hdr_ready,
  output logic [7:0]            hdr_type,
  output logic [SERIAL_W-1:0]   hdr_serial,
  output logic [ERR_W-1:0]      hdr_err,
  input  logic                  daq_done,
  input  logic                  seq_resync,
  output logic [TRIG_CNT_W-1:0] trig_cnt,
  output logic [ERR_CNT_W-1:0]  crc_err_cnt,
  output logic [ERR_CNT_W-1:0]  seq_err_cnt,
  output logic [ERR_CNT_W-1:0]  lost_trig_cnt,
  output logic [2:0]            state_dbg
);

  // Header handshake: hdr_valid rises with stable hdr_type/hdr_serial/hdr_err,
  // which hold until the first cycle hdr_ready is sampled high; that cycle is
  // the transfer and hdr_valid drops on the following edge.

  state_t                state_q, state_n;
  logic                  trig_d, trig_edge;
  logic [31:0]           tmo_q, tmo_n;
  logic [7:0]            phase_q, phase_n;
  logic                  done_seen_q, done_seen_n;
  logic [SERIAL_W-1:0]   exp_serial_q, exp_serial_n;
  logic                  resync_pend_q, resync_pend_n;
  logic                  daq_trig_n, busy_clear_n, hdr_valid_n;
  logic [7:0]            hdr_type_n;
  logic [SERIAL_W-1:0]   hdr_serial_n;
  logic [ERR_W-1:0]      hdr_err_n;
  logic                  trig_inc, crc_inc, seq_inc, lost_inc;
  logic                  pkt_crc_err, pkt_id_err, pkt_seq_err;

  assign state_dbg   = state_q;
  assign pkt_crc_err = ~crc_status;
  assign pkt_id_err  = (sub_system_id != SUBSYS_ID);
  assign pkt_seq_err = (trigger_serial != exp_serial_q) & ~resync_pend_q;
  assign lost_inc    = trig_edge & (state_q != ST_IDLE);

  always_comb begin
    state_n       = state_q;
    tmo_n         = tmo_q;
    phase_n       = phase_q;
    done_seen_n   = done_seen_q;
    exp_serial_n  = exp_serial_q;
    resync_pend_n = resync_pend_q;
    daq_trig_n    = 1'b0;
    busy_clear_n  = busy_clear;
    hdr_valid_n   = hdr_valid;
    hdr_type_n    = hdr_type;
    hdr_serial_n  = hdr_serial;
    hdr_err_n     = hdr_err;
    trig_inc      = 1'b0;
    crc_inc       = 1'b0;
    seq_inc       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig_edge) begin
          daq_trig_n = 1'b1;
          trig_inc   = 1'b1;
          tmo_n      = '0;
          state_n    = ST_WAIT_PKT;
        end
      end
      ST_WAIT_PKT: begin
        // end_flag takes priority over a timeout in the same cycle
        if (end_flag) begin
          hdr_type_n   = trigger_type;
          hdr_serial_n = trigger_serial;
          hdr_err_n    = make_hdr_err(1'b0, pkt_seq_err, pkt_id_err, pkt_crc_err);
          crc_inc      = pkt_crc_err;
          seq_inc      = pkt_seq_err;
          if (crc_status) begin
            exp_serial_n  = trigger_serial + 32'd1;
            resync_pend_n = 1'b0;
          end
          hdr_valid_n = 1'b1;
          done_seen_n = 1'b0;
          state_n     = ST_WAIT_DAQ;
        end else if (tmo_q == 32'(TIMEOUT_CYC - 1)) begin
          hdr_type_n   = 8'hFF;
          hdr_serial_n = exp_serial_q;
          hdr_err_n    = make_hdr_err(1'b1, 1'b0, 1'b0, 1'b0);
          hdr_valid_n  = 1'b1;
          done_seen_n  = 1'b0;
          state_n      = ST_WAIT_DAQ;
        end else begin
          tmo_n = tmo_q + 32'd1;
        end
      end
      ST_WAIT_DAQ: begin
        if (hdr_valid && hdr_ready) hdr_valid_n = 1'b0;
        if (daq_done) done_seen_n = 1'b1;
        if (!hdr_valid_n && done_seen_n) begin
          busy_clear_n = 1'b1;
          phase_n      = '0;
          state_n      = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (phase_q == 8'(CLEAR_LEN - 1)) begin
          busy_clear_n = 1'b0;
          phase_n      = '0;
          state_n      = ST_REARM;
        end else begin
          phase_n = phase_q + 8'd1;
        end
      end
      ST_REARM: begin
        // two low cycles so the receiver always sees a fresh rising edge
        if (phase_q == 8'd1) begin
          state_n = ST_IDLE;
        end else begin
          phase_n = phase_q + 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (seq_resync) resync_pend_n = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      trig_d        <= 1'b0;
      trig_edge     <= 1'b0;
      tmo_q         <= '0;
      phase_q       <= '0;
      done_seen_q   <= 1'b0;
      exp_serial_q  <= '0;
      resync_pend_q <= 1'b1;
      daq_trig      <= 1'b0;
      busy_clear    <= 1'b0;
      hdr_valid     <= 1'b0;
      hdr_type      <= '0;
      hdr_serial    <= '0;
      hdr_err       <= '0;
      trig_cnt      <= '0;
    end else begin
      state_q       <= state_n;
      trig_d        <= trigger;
      trig_edge     <= trigger & ~trig_d;
      tmo_q         <= tmo_n;
      phase_q       <= phase_n;
      done_seen_q   <= done_seen_n;
      exp_serial_q  <= exp_serial_n;
      resync_pend_q <= resync_pend_n;
      daq_trig      <= daq_trig_n;
      busy_clear    <= busy_clear_n;
      hdr_valid     <= hdr_valid_n;
      hdr_type      <= hdr_type_n;
      hdr_serial    <= hdr_serial_n;
      hdr_err       <= hdr_err_n;
      if (trig_inc) trig_cnt <= trig_cnt + 32'd1;
    end
  end

  sat_counter #(.WIDTH(ERR_CNT_W)) u_crc_cnt (
    .clk(clk), .reset(reset), .clear(1'b0), .inc(crc_inc), .count(crc_err_cnt)
  );

  sat_counter #(.WIDTH(ERR_CNT_W)) u_seq_cnt (
    .clk(clk), .reset(reset), .clear(1'b0), .inc(seq_inc), .count(seq_err_cnt)
  );

  sat_counter #(.WIDTH(ERR_CNT_W)) u_lost_cnt (
    .clk(clk), .reset(reset), .clear(1'b0), .inc(lost_inc), .count(lost_trig_cnt)
  );

endmodule

// File: tb/tb_trigger_daq_sequencer.sv
// Directed bench for trigger_daq_sequencer with hand-computed expectations.
module tb_trigger_daq_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic        end_flag = 1'b0;
  logic        crc_status = 1'b0;
  logic [7:0]  sub_system_id = 8'h00;
  logic [7:0]  trigger_type = 8'h00;
  logic [31:0] trigger_serial = 32'h0;
  logic        busy_clear;
  logic        daq_trig;
  logic        hdr_valid;
  logic        hdr_ready = 1'b1;
  logic [7:0]  hdr_type;
  logic [31:0] hdr_serial;
  logic [3:0]  hdr_err;
  logic        daq_done = 1'b0;
  logic        seq_resync = 1'b0;
  logic [31:0] trig_cnt;
  logic [15:0] crc_err_cnt;
  logic [15:0] seq_err_cnt;
  logic [15:0] lost_trig_cnt;
  logic [2:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  trigger_daq_sequencer #(
    .SUBSYS_ID(8'h00), .TIMEOUT_CYC(50), .CLEAR_LEN(4)
  ) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .end_flag(end_flag),
    .crc_status(crc_status), .sub_system_id(sub_system_id),
    .trigger_type(trigger_type), .trigger_serial(trigger_serial),
    .busy_clear(busy_clear), .daq_trig(daq_trig), .hdr_valid(hdr_valid),
    .hdr_ready(hdr_ready), .hdr_type(hdr_type), .hdr_serial(hdr_serial),
    .hdr_err(hdr_err), .daq_done(daq_done), .seq_resync(seq_resync),
    .trig_cnt(trig_cnt), .crc_err_cnt(crc_err_cnt), .seq_err_cnt(seq_err_cnt),
    .lost_trig_cnt(lost_trig_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic fire_trigger(input string tag);
    trigger = 1'b1;
    tick();
    check({tag, "_daq_trig_c1"}, {31'd0, daq_trig}, 32'd0);
    tick();
    check({tag, "_daq_trig_c2"}, {31'd0, daq_trig}, 32'd1);
    trigger = 1'b0;
  endtask

  task automatic send_pkt(input string tag, input logic crc, input logic [7:0] id,
                          input logic [7:0] typ, input logic [31:0] serial,
                          input logic [3:0] exp_err);
    end_flag       = 1'b1;
    crc_status     = crc;
    sub_system_id  = id;
    trigger_type   = typ;
    trigger_serial = serial;
    tick();
    end_flag = 1'b0;
    check({tag, "_hdr_valid"},  {31'd0, hdr_valid}, 32'd1);
    check({tag, "_hdr_err"},    {28'd0, hdr_err},   {28'd0, exp_err});
    check({tag, "_hdr_type"},   {24'd0, hdr_type},  {24'd0, typ});
    check({tag, "_hdr_serial"}, hdr_serial,         serial);
  endtask

  // Called right after busy_clear was seen rising; counts its high time and
  // walks through the two re-arm cycles back to idle.
  task automatic finish_clear(input string tag);
    int hi;
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy_clear) hi++;
      else break;
    end
    check({tag, "_busy_len"}, hi, 32'd4);
    tick();
    check({tag, "_rearm"}, {29'd0, state_dbg}, 32'd4);
    tick();
    check({tag, "_idle"}, {29'd0, state_dbg}, 32'd0);
  endtask

  task automatic run_readout(input string tag);
    daq_done = 1'b1;
    tick();
    daq_done = 1'b0;
    check({tag, "_busy_rise"}, {31'd0, busy_clear}, 32'd1);
    finish_clear(tag);
  endtask

  initial begin
    int cyc;
    int extra_trig;
    int busy_seen;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    check("rst_busy_clear", {31'd0, busy_clear}, 32'd0);
    check("rst_daq_trig",   {31'd0, daq_trig},   32'd0);
    check("rst_hdr_valid",  {31'd0, hdr_valid},  32'd0);
    check("rst_hdr_err",    {28'd0, hdr_err},    32'd0);
    check("rst_trig_cnt",   trig_cnt,            32'd0);
    check("rst_state",      {29'd0, state_dbg},  32'd0);

    // stray end_flag in IDLE must be ignored
    end_flag = 1'b1; crc_status = 1'b0;
    tick();
    end_flag = 1'b0;
    tick();
    check("idle_eflag_valid", {31'd0, hdr_valid}, 32'd0);
    check("idle_eflag_crc",   {16'd0, crc_err_cnt}, 32'd0);

    // first packet after reset: serial 5 re-seeds, no errors
    fire_trigger("t1");
    send_pkt("t1", 1'b1, 8'h00, 8'h11, 32'd5, 4'b0000);
    tick();
    check("t1_hs_clear", {31'd0, hdr_valid}, 32'd0);
    run_readout("t1");
    check("t1_trig_cnt", trig_cnt, 32'd1);

    // serial 7 when 6 expected
    fire_trigger("t2");
    send_pkt("t2", 1'b1, 8'h00, 8'h22, 32'd7, 4'b0100);
    check("t2_seq_cnt", {16'd0, seq_err_cnt}, 32'd1);
    run_readout("t2");

    // crc failure with the expected serial 8; exp_serial stays 8
    fire_trigger("t3");
    send_pkt("t3", 1'b0, 8'h00, 8'h33, 32'd8, 4'b0001);
    check("t3_crc_cnt", {16'd0, crc_err_cnt}, 32'd1);
    run_readout("t3");

    fire_trigger("t4");
    send_pkt("t4", 1'b1, 8'h00, 8'h44, 32'd8, 4'b0000);
    run_readout("t4");

    // wrong sub-system id, serial 9 in sequence
    fire_trigger("t4b");
    send_pkt("t4b", 1'b1, 8'h5A, 8'h45, 32'd9, 4'b0010);
    run_readout("t4b");

    // timeout: hdr_valid 50 cycles after entering WAIT_PKT
    fire_trigger("t5");
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      cyc++;
      if (hdr_valid) break;
    end
    check("t5_tmo_cycles", cyc, 32'd50);
    check("t5_hdr_err",    {28'd0, hdr_err},  32'h8);
    check("t5_hdr_type",   {24'd0, hdr_type}, 32'hFF);
    check("t5_hdr_serial", hdr_serial,        32'd10);
    run_readout("t5");

    // lost trigger in WAIT_DAQ and delayed hdr_ready
    fire_trigger("t6");
    hdr_ready = 1'b0;
    send_pkt("t6", 1'b1, 8'h00, 8'h55, 32'd10, 4'b0000);
    extra_trig = 0;
    trigger = 1'b1;
    tick(); if (daq_trig) extra_trig++;
    tick(); if (daq_trig) extra_trig++;
    trigger = 1'b0;
    tick(); if (daq_trig) extra_trig++;
    check("t6_lost_cnt",   {16'd0, lost_trig_cnt}, 32'd1);
    check("t6_no_daqtrig", extra_trig,             32'd0);
    check("t6_trig_cnt",   trig_cnt,               32'd7);
    daq_done = 1'b1;
    tick();
    daq_done = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy_clear) busy_seen++;
    end
    check("t6_busy_held", busy_seen,              32'd0);
    check("t6_valid_held", {31'd0, hdr_valid},    32'd1);
    hdr_ready = 1'b1;
    tick();
    check("t6_hs_valid", {31'd0, hdr_valid},  32'd0);
    check("t6_busy_rise", {31'd0, busy_clear}, 32'd1);
    finish_clear("t6");

    // resync, then 32'hFFFFFFFF followed by 0
    seq_resync = 1'b1;
    tick();
    seq_resync = 1'b0;
    fire_trigger("t7");
    send_pkt("t7", 1'b1, 8'h00, 8'h66, 32'hFFFF_FFFF, 4'b0000);
    run_readout("t7");
    fire_trigger("t7b");
    send_pkt("t7b", 1'b1, 8'h00, 8'h67, 32'h0, 4'b0000);
    run_readout("t7b");
    check("t7_seq_cnt",  {16'd0, seq_err_cnt}, 32'd1);
    check("t7_trig_cnt", trig_cnt,             32'd9);

    // asynchronous reset during CLEAR
    fire_trigger("t8");
    send_pkt("t8", 1'b1, 8'h00, 8'h77, 32'd1, 4'b0000);
    daq_done = 1'b1;
    tick();
    daq_done = 1'b0;
    check("t8_busy_rise", {31'd0, busy_clear}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t8_rst_busy",  {31'd0, busy_clear},    32'd0);
    check("t8_rst_trig",  trig_cnt,               32'd0);
    check("t8_rst_crc",   {16'd0, crc_err_cnt},   32'd0);
    check("t8_rst_seq",   {16'd0, seq_err_cnt},   32'd0);
    check("t8_rst_lost",  {16'd0, lost_trig_cnt}, 32'd0);
    check("t8_rst_state", {29'd0, state_dbg},     32'd0);
    check("t8_rst_valid", {31'd0, hdr_valid},     32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
